// File: rtl/ram_banked_dp_if.sv
// ram_banked_dp_if: write/read port bundle for ram_banked_dp
interface ram_banked_dp_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 12
);
  logic [DATA_W-1:0] data_in, data_out;
  logic [ADDR_W-1:0] wr_address, rd_address;
  logic write, read, rd_valid, init_done;
  modport master (output data_in, wr_address, write, rd_address, read, input data_out, rd_valid, init_done);
  modport slave (input data_in, wr_address, write, rd_address, read, output data_out, rd_valid, init_done);
endinterface

// File: rtl/ram_banked_dp.sv
// ram_banked_dp: banked 1W/1R RAM with post-reset zeroing sweep.
// RAM_BYPASS_EN selects write-first forwarding on same-address collisions (default read-first).
module ram_banked_dp #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 12,
  parameter int BANK_SEL_W = 2
) (
  input logic clk,
  input logic resetn,
  ram_banked_dp_if.slave bus
);
  localparam int ROW_W = ADDR_W - BANK_SEL_W;
  localparam int BS = BANK_SEL_W > 0 ? BANK_SEL_W : 1;
  localparam int BANKS = 1 << BANK_SEL_W;
  localparam int ROWS = 1 << ROW_W;
`ifdef RAM_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  typedef enum logic {CLEAR, READY} state_t;
  state_t state_q, state_d;
  logic [ROW_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] mem [BANKS][ROWS];
  logic [BS-1:0] wr_bank, rd_bank;
  logic [ROW_W-1:0] wr_row, rd_row, w_row;
  logic [DATA_W-1:0] w_data;
  logic [BANKS-1:0] we;
  logic ready;
  // shifting out the row bits yields bank 0 when there is a single bank
  assign wr_bank = BS'(bus.wr_address >> ROW_W);
  assign rd_bank = BS'(bus.rd_address >> ROW_W);
  assign wr_row = bus.wr_address[ROW_W-1:0];
  assign rd_row = bus.rd_address[ROW_W-1:0];
  assign ready = state_q == READY;
  always_comb begin
    state_d = (state_q == CLEAR && &cnt_q) ? READY : state_q;
    cnt_d = ready ? cnt_q : cnt_q + 1'b1;
    w_row = ready ? wr_row : cnt_q;
    w_data = ready ? bus.data_in : '0;
    we = '0;
    for (int b = 0; b < BANKS; b++) we[b] = !ready || (bus.write && wr_bank == BS'(b));
    rd_valid_d = ready && bus.read;
    data_out_d = !rd_valid_d ? data_out_q :
                 (BYPASS && bus.write && bus.wr_address == bus.rd_address) ? bus.data_in :
                 mem[rd_bank][rd_row];
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= CLEAR;
      cnt_q <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
    end
  // storage is cleared only by the sweep, never by reset
  always_ff @(posedge clk)
    for (int b = 0; b < BANKS; b++)
      if (we[b]) mem[b][w_row] <= w_data;
  assign bus.data_out = data_out_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.init_done = ready;
endmodule

// File: tb/tb_ram_banked_dp.sv
// tb_ram_banked_dp: directed self-checking bench for ram_banked_dp
module tb_ram_banked_dp;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int total = 0;
  int bad = 0;
  int n;
  bit sv;
  ram_banked_dp_if #(.DATA_W(64), .ADDR_W(12)) bus ();
  ram_banked_dp #(.DATA_W(64), .ADDR_W(12), .BANK_SEL_W(2)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [11:0] a, input logic [63:0] d);
    bus.write = 1'b1;
    bus.wr_address = a;
    bus.data_in = d;
    tick();
    bus.write = 1'b0;
  endtask
  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [63:0] exp);
    bus.read = 1'b1;
    bus.rd_address = a;
    tick();
    bus.read = 1'b0;
    chk({tag, "_valid"}, 64'(bus.rd_valid), 64'd1);
    chk(tag, bus.data_out, exp);
  endtask
  task automatic sweep(output int cyc, output bit saw_valid);
    cyc = 0;
    saw_valid = 1'b0;
    while (!bus.init_done && cyc < 2000) begin
      tick();
      cyc++;
      saw_valid |= bus.rd_valid;
    end
  endtask
  initial begin
    bus.read = 1'b1;
    bus.rd_address = 12'h000;
    bus.write = 1'b1;
    bus.wr_address = 12'h010;
    bus.data_in = 64'hDEAD;
    tick();
    tick();
    chk("rst_data_out", bus.data_out, 64'd0);
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("rst_init_done", 64'(bus.init_done), 64'd0);
    resetn = 1'b1;
    sweep(n, sv);
    bus.write = 1'b0;
    chk("sweep_len", 64'(n), 64'd1024);
    chk("sweep_no_valid", 64'(sv), 64'd0);
    tick();
    chk("first_read_valid", 64'(bus.rd_valid), 64'd1);
    chk("first_read_data", bus.data_out, 64'd0);
    bus.read = 1'b0;
    tick();
    chk("valid_drop", 64'(bus.rd_valid), 64'd0);
    wr(12'h000, 64'hA0);
    wr(12'h400, 64'hA1);
    wr(12'h800, 64'hA2);
    wr(12'hC00, 64'hA3);
    rd_chk("bank0", 12'h000, 64'hA0);
    rd_chk("bank1", 12'h400, 64'hA1);
    rd_chk("bank2", 12'h800, 64'hA2);
    rd_chk("bank3", 12'hC00, 64'hA3);
    rd_chk("bank0_row1", 12'h001, 64'd0);
    for (int i = 0; i < 16; i++) wr(12'(i), 64'(i * 16'h0101));
    bus.read = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.rd_address = 12'(i);
      tick();
      chk($sformatf("stream_valid%0d", i), 64'(bus.rd_valid), 64'd1);
      chk($sformatf("stream_data%0d", i), bus.data_out, 64'(i * 16'h0101));
    end
    bus.read = 1'b0;
    tick();
    chk("stream_end_valid", 64'(bus.rd_valid), 64'd0);
    chk("stream_hold", bus.data_out, 64'h0F0F);
    wr(12'h123, 64'h5555);
    bus.write = 1'b1;
    bus.wr_address = 12'h123;
    bus.data_in = 64'hAAAA;
    bus.read = 1'b1;
    bus.rd_address = 12'h123;
    tick();
    bus.write = 1'b0;
    bus.read = 1'b0;
`ifdef RAM_BYPASS_EN
    chk("collide", bus.data_out, 64'hAAAA);
`else
    chk("collide", bus.data_out, 64'h5555);
`endif
    rd_chk("collide_after", 12'h123, 64'hAAAA);
    rd_chk("clear_ignores_wr", 12'h010, 64'd0);
    wr(12'h7FF, 64'hFFFF);
    rd_chk("pre_rst_7ff", 12'h7FF, 64'hFFFF);
    resetn = 1'b0;
    #2;
    chk("rst2_init_done", 64'(bus.init_done), 64'd0);
    chk("rst2_data_out", bus.data_out, 64'd0);
    resetn = 1'b1;
    repeat (300) tick();
    chk("mid_sweep_busy", 64'(bus.init_done), 64'd0);
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
    sweep(n, sv);
    chk("resweep_len", 64'(n), 64'd1024);
    rd_chk("post_rst_7ff", 12'h7FF, 64'd0);
    rd_chk("post_rst_123", 12'h123, 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
